// File: rtl/text_console_if.sv
// Byte stream into the text console.
// Valid/ready handshake carrying a byte and its attribute bit.
interface text_console_if;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       in_attr;

    modport master (
        output in_valid,
        output in_data,
        output in_attr,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  in_attr,
        output in_ready
    );
endinterface

// File: rtl/text_console.sv
// TTY-style sequencer for the text-mode display write port.
// Prints bytes, moves the cursor and runs row/screen clears.
module text_console #(
    parameter int COLS = 80,
    parameter int ROWS = 60,
    parameter int TAB  = 8
) (
    input  logic          clk_sys,
    input  logic          btn_rst_n,
    text_console_if.slave in_if,
    output logic [6:0]    char_x,
    output logic [5:0]    char_y,
    output logic [8:0]    char_chr,
    output logic          char_str,
    output logic [6:0]    cur_x,
    output logic [5:0]    cur_y,
    output logic          busy
);

    typedef enum logic [1:0] {
        CLR_SCREEN,
        CLR_ROW,
        IDLE
    } state_t;

    localparam logic [7:0] COLS_W = 8'(COLS);
    localparam logic [7:0] END_X  = 8'(COLS - 1);
    localparam logic [6:0] ROWS_W = 7'(ROWS);
    localparam logic [6:0] LAST_X = 7'(COLS - 1);
    localparam logic [5:0] LAST_Y = 6'(ROWS - 1);
    localparam logic [7:0] TAB_M  = 8'(TAB - 1);
    localparam logic [7:0] SCR_X1 = (COLS == 1) ? 8'd0 : 8'd1;
    localparam logic [6:0] SCR_Y1 = (COLS == 1) ? 7'd1 : 7'd0;
    localparam logic [8:0] BLANK  = 9'h020;

    state_t     state_q, state_d;
    logic [7:0] cnt_x_q, cnt_x_d;
    logic [6:0] cnt_y_q, cnt_y_d;
    logic [6:0] cur_x_q, cur_x_d;
    logic [5:0] cur_y_q, cur_y_d;
    logic [6:0] wx_d;
    logic [5:0] wy_d;
    logic [8:0] wc_d;
    logic       ws_d;

    logic       accept;
    logic [7:0] d;
    logic       is_print, is_cr, is_lf, is_bs, is_tab, is_ff;
    logic [5:0] nl_y;
    logic [7:0] tab_x;
    logic       tab_wrap;

    assign in_if.in_ready = (state_q == IDLE);
    assign busy           = (state_q != IDLE);
    assign cur_x          = cur_x_q;
    assign cur_y          = cur_y_q;

    assign accept   = in_if.in_valid && (state_q == IDLE);
    assign d        = in_if.in_data;
    assign is_print = (d >= 8'h20) && (d != 8'h7F);
    assign is_cr    = (d == 8'h0D);
    assign is_lf    = (d == 8'h0A);
    assign is_bs    = (d == 8'h08);
    assign is_tab   = (d == 8'h09);
    assign is_ff    = (d == 8'h0C);
    assign nl_y     = (cur_y_q == LAST_Y) ? 6'd0 : cur_y_q + 6'd1;
    assign tab_x    = ({1'b0, cur_x_q} | TAB_M) + 8'd1;
    assign tab_wrap = (tab_x >= COLS_W);

    // State, counters, cursor and the registered write port
    always_ff @(posedge clk_sys or negedge btn_rst_n) begin
        if (!btn_rst_n) begin
            state_q  <= CLR_SCREEN;
            cnt_x_q  <= '0;
            cnt_y_q  <= '0;
            cur_x_q  <= '0;
            cur_y_q  <= '0;
            char_x   <= '0;
            char_y   <= '0;
            char_chr <= '0;
            char_str <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_x_q  <= cnt_x_d;
            cnt_y_q  <= cnt_y_d;
            cur_x_q  <= cur_x_d;
            cur_y_q  <= cur_y_d;
            char_x   <= wx_d;
            char_y   <= wy_d;
            char_chr <= wc_d;
            char_str <= ws_d;
        end
    end

    // Next state: clears walk cells, IDLE decodes the accepted byte.
    // A newline strobes cell 0 of the new row on the accept edge itself.
    always_comb begin
        state_d = state_q;
        cnt_x_d = cnt_x_q;
        cnt_y_d = cnt_y_q;
        cur_x_d = cur_x_q;
        cur_y_d = cur_y_q;
        wx_d    = char_x;
        wy_d    = char_y;
        wc_d    = char_chr;
        ws_d    = 1'b0;
        unique case (state_q)
            CLR_SCREEN: begin
                if (cnt_y_q == ROWS_W) begin
                    state_d = IDLE;
                end else begin
                    ws_d = 1'b1;
                    wx_d = cnt_x_q[6:0];
                    wy_d = cnt_y_q[5:0];
                    wc_d = BLANK;
                    if (cnt_x_q == END_X) begin
                        cnt_x_d = 8'd0;
                        cnt_y_d = cnt_y_q + 7'd1;
                    end else begin
                        cnt_x_d = cnt_x_q + 8'd1;
                    end
                end
            end
            CLR_ROW: begin
                if (cnt_x_q == COLS_W) begin
                    state_d = IDLE;
                end else begin
                    ws_d    = 1'b1;
                    wx_d    = cnt_x_q[6:0];
                    wy_d    = cur_y_q;
                    wc_d    = BLANK;
                    cnt_x_d = cnt_x_q + 8'd1;
                end
            end
            IDLE: begin
                if (accept) begin
                    unique case (1'b1)
                        is_print: begin
                            ws_d = 1'b1;
                            wx_d = cur_x_q;
                            wy_d = cur_y_q;
                            wc_d = {in_if.in_attr, d};
                            if (cur_x_q == LAST_X) begin
                                cur_x_d = 7'd0;
                                cur_y_d = nl_y;
                                cnt_x_d = 8'd0;
                                state_d = CLR_ROW;
                            end else begin
                                cur_x_d = cur_x_q + 7'd1;
                            end
                        end
                        is_cr: cur_x_d = 7'd0;
                        is_lf, is_tab: begin
                            if (is_lf || tab_wrap) begin
                                cur_x_d = 7'd0;
                                cur_y_d = nl_y;
                                ws_d    = 1'b1;
                                wx_d    = 7'd0;
                                wy_d    = nl_y;
                                wc_d    = BLANK;
                                cnt_x_d = 8'd1;
                                state_d = CLR_ROW;
                            end else begin
                                cur_x_d = tab_x[6:0];
                            end
                        end
                        is_bs: begin
                            if (cur_x_q != 7'd0) begin
                                cur_x_d = cur_x_q - 7'd1;
                                ws_d    = 1'b1;
                                wx_d    = cur_x_q - 7'd1;
                                wy_d    = cur_y_q;
                                wc_d    = BLANK;
                            end
                        end
                        is_ff: begin
                            cur_x_d = 7'd0;
                            cur_y_d = 6'd0;
                            ws_d    = 1'b1;
                            wx_d    = 7'd0;
                            wy_d    = 6'd0;
                            wc_d    = BLANK;
                            cnt_x_d = SCR_X1;
                            cnt_y_d = SCR_Y1;
                            state_d = CLR_SCREEN;
                        end
                        default: ;
                    endcase
                end
            end
            default: state_d = CLR_SCREEN;
        endcase
    end

endmodule

// File: doc/text_console.md
# text_console

TTY-style controller that sequences the character write port of the text-mode VGA display. It accepts a byte stream over a valid/ready handshake and maintains a cursor. It turns printable bytes into single-cycle character writes and expands control codes (CR, LF, BS, TAB, FF) into cursor moves and multi-cycle row or screen clears. It sits between the CPU core and the display, driving char_x/char_y/char_chr/char_str directly.

## Interface
- COLS, 80, visible columns; 1..128.
- ROWS, 60, visible rows; 1..64.
- TAB, 8, tab stop spacing; power of two, at most COLS.
- clk_sys  in  1  system clock; single clock domain.
- btn_rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  input byte valid.
- in_ready  out  1  block can accept a byte this cycle.
- in_data  in  8  byte to display or interpret.
- in_attr  in  1  attribute bit; becomes char_chr[8] for printable writes.
- char_x  out  7  write column.
- char_y  out  6  write row.
- char_chr  out  9  {attr, code} written.
- char_str  out  1  write strobe; one cycle per character cell.
- cur_x  out  7  current cursor column.
- cur_y  out  6  current cursor row.
- busy  out  1  high while a clear sequence runs.

## Operation
- States: CLR_SCREEN, CLR_ROW, IDLE.
- Reset puts the block in CLR_SCREEN with cursor (0,0).
- A byte is accepted when in_valid && in_ready.
- in_ready = (state == IDLE). busy = !in_ready.
- Printable bytes (0x20–0x7E, 0x80–0xFF):
  - Write {in_attr, in_data} at (cur_x, cur_y).
  - Then cur_x+1.
  - If cur_x was COLS-1, perform a newline instead of the increment.
- 0x0D CR: cur_x ← 0. No write.
- 0x0A LF: newline.
- 0x08 BS:
  - If cur_x > 0: cur_x ← cur_x-1 and write 9'h020 at the new position.
  - At cur_x = 0: no-op, no write.
- 0x09 TAB: cur_x ← (cur_x | (TAB-1)) + 1. If the result ≥ COLS, newline. No write.
- 0x0C FF: cursor ← (0,0), then enter CLR_SCREEN.
- Other bytes 0x00–0x1F and 0x7F: accepted, no effect.
- Newline sequence:
  - cur_x ← 0.
  - cur_y ← (cur_y == ROWS-1) ? 0 : cur_y+1. No scrolling; the cursor wraps to the top.
  - Enter CLR_ROW for the new cur_y.
- CLR_ROW: one strobe per cycle, char_x = 0..COLS-1, char_y = cur_y, char_chr = 9'h020. Then go to IDLE.
- CLR_SCREEN: COLS×ROWS strobes in raster order (x fastest), char_chr = 9'h020. Then go to IDLE.
- Cursor and counter arithmetic is unsigned and uses the widths above. Comparisons are against COLS-1 / ROWS-1, never against the power-of-two wrap.

## Timing
- Reset values:
  - char_x = 0, char_y = 0, char_chr = 0, char_str = 0.
  - cur_x = 0, cur_y = 0.
  - in_ready = 0, busy = 1.
- All char_* outputs are registered.
- A byte accepted at edge E produces its char_str at edge E, visible in cycle E+1. Latency is 1 cycle.
- Printable bytes can be accepted every cycle in IDLE, giving one strobe per cycle.
- Printable byte at column COLS-1, accepted at edge E:
  - Its write is strobed in cycle E+1.
  - in_ready is low from cycle E+1.
  - Clear strobes occupy cycles E+2 .. E+1+COLS.
  - in_ready returns high in cycle E+2+COLS.
- LF or overflowing TAB accepted at E: in_ready is low for exactly COLS cycles starting at E+1, and clear strobes occupy cycles E+1..E+COLS.
- FF accepted at E: COLS×ROWS strobes starting at E+1.
- Post-reset clear:
  - First strobe appears in the first cycle after btn_rst_n deasserts plus one edge.
  - Exactly COLS×ROWS strobes follow, then in_ready rises.
- cur_x/cur_y update on the acceptance edge, so they already show the post-newline row during CLR_ROW.
- No strobe is produced for CR, ignored codes, BS at column 0, or non-wrapping TAB.
- Reset asserted mid-sequence: all outputs are forced to reset values immediately (asynchronously). The in-progress clear is abandoned, and the full screen clear restarts after release.

## Test plan
- Reset release → 4800 strobes, (0,0)…(79,59) in raster order, each char_chr = 0x020; then in_ready = 1, cursor (0,0).
- After idle, "A","B" back-to-back with in_attr = 1 → strobes (0,0,0x141) then (1,0,0x142) in consecutive cycles; cur_x = 2.
- 80 × 0x78 on row 0 → 80th write at (79,0,0x078); then 80 strobes clearing row 1; in_ready low exactly 81 cycles after the 80th accept; cursor (0,1).
- Cursor at (10,59), LF → cursor (0,0), row 0 cleared with 80 strobes, no scrolling.
- At x = 3: TAB → cur_x = 8, no strobe. At x = 0: BS → no strobe. At x = 5: BS → strobe (4,y,0x020), cur_x = 4. At x = 75: TAB → newline plus row clear.
- FF at (20,7) → 4800 clear strobes, cursor (0,0). btn_rst_n pulsed after 1000 of those strobes → char_str drops at once; a full 4800-strobe clear follows release.
